// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: widths,
// requester encoding and the hard-wired zero register.
package reg_wb_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. req_i/gnt_o bit 0 is the ALU and bit 1 is MEM.
// The pointer always moves to the loser of the last grant, even an uncontended one.
module rr_arb2
  import reg_wb_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       last_grant_o
);

  logic ptr_q, ptr_d;
  logic last_q, last_d;

  // Grants are gated by reset so that neither requester sees ready while reset is held.
  always_comb begin
    gnt_o = 2'b00;
    if (rst_ni) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_q == REQ_MEM) ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    if (gnt_o[0]) begin
      ptr_d  = REQ_MEM;
      last_d = REQ_ALU;
    end else if (gnt_o[1]) begin
      ptr_d  = REQ_ALU;
      last_d = REQ_MEM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= REQ_ALU;
      last_q <= REQ_ALU;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  assign last_grant_o = last_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths,
// with a one-deep registered write stage and a pending-write mask for decode.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = reg_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = reg_wb_arbiter_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_reg,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   writeReg,
  output logic [DATA_W-1:0]   writeValue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                last_grant
);

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_value_q, write_value_d;

  rr_arb2 u_arb (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .req_i        ({mem_valid, alu_valid}),
    .gnt_o        (gnt),
    .last_grant_o (last_grant)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];

  assign sel_reg  = gnt[1] ? mem_reg  : alu_reg;
  assign sel_data = gnt[1] ? mem_data : alu_data;

  // Register 0 is granted like any other write but lands as a zeroed no-op.
  always_comb begin
    reg_write_d   = 1'b0;
    write_reg_d   = write_reg_q;
    write_value_d = write_value_q;
    if (|gnt) begin
      if (sel_reg == ADDR_W'(ZERO_REG)) begin
        write_reg_d   = '0;
        write_value_d = '0;
      end else begin
        reg_write_d   = 1'b1;
        write_reg_d   = sel_reg;
        write_value_d = sel_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_write_q   <= 1'b0;
      write_reg_q   <= '0;
      write_value_q <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      write_reg_q   <= write_reg_d;
      write_value_q <= write_value_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign writeReg   = write_reg_q;
  assign writeValue = write_value_q;

  assign busy_mask[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_mask[gi] = (reg_write_q && (write_reg_q == ADDR_W'(gi)))
                          || (alu_valid   && (alu_reg     == ADDR_W'(gi)))
                          || (mem_valid   && (mem_reg     == ADDR_W'(gi)));
    end
  endgenerate

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed scenarios then randomized traffic,
// expected writes queued at grant time and checked by an independent monitor.
module tb_reg_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        alu_valid, mem_valid;
  logic [2:0]  alu_reg, mem_reg;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        RegWrite;
  logic [2:0]  writeReg;
  logic [15:0] writeValue;
  logic [7:0]  busy_mask;
  logic        last_grant;

  reg_wb_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeValue (writeValue),
    .busy_mask  (busy_mask),
    .last_grant (last_grant)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [2:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Reference model state: who is favoured next, who won last, and what the
  // write port should currently be showing.
  int          m_pref;
  int          m_last;
  bit          m_we;
  logic [2:0]  m_reg;
  logic [15:0] m_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pref = 0;
    m_last = 0;
    m_we   = 1'b0;
    m_reg  = '0;
    m_val  = '0;
  endtask

  // Monitor: every write the DUT presents must be the next expected one, in the expected cycle.
  always @(negedge CLK) begin
    wr_t e;
    cyc++;
    if (RST_N === 1'b1 && RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {29'd0, writeReg}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_reg", {29'd0, writeReg}, {29'd0, e.r});
        chk("wr_val", {16'd0, writeValue}, {16'd0, e.d});
        $display("write reg%0d=%h cycle %0d", writeReg, writeValue, cyc);
      end
    end
  end

  // One cycle of traffic: drive requests, check handshake/mask, advance the model.
  task automatic step(input bit av, input logic [2:0] ar, input logic [15:0] ad,
                      input bit mv, input logic [2:0] mr, input logic [15:0] md,
                      output bit ga, output bit gm);
    logic [7:0]  exp_busy;
    int          win;
    logic [2:0]  wr;
    logic [15:0] wd;
    @(negedge CLK);
    #1;
    chk("writeReg_hold", {29'd0, writeReg}, {29'd0, m_reg});
    chk("writeValue_hold", {16'd0, writeValue}, {16'd0, m_val});
    chk("last_grant", {31'd0, last_grant}, m_last);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    #1;
    win = -1;
    if (av && mv) win = m_pref;
    else if (av) win = 0;
    else if (mv) win = 1;
    ga = (win == 0);
    gm = (win == 1);
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ga});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, gm});
    exp_busy = '0;
    if (m_we) exp_busy[m_reg] = 1'b1;
    if (av) exp_busy[ar] = 1'b1;
    if (mv) exp_busy[mr] = 1'b1;
    exp_busy[0] = 1'b0;
    chk("busy_mask", {24'd0, busy_mask}, {24'd0, exp_busy});
    m_we = 1'b0;
    if (win >= 0) begin
      wr = (win == 0) ? ar : mr;
      wd = (win == 0) ? ad : md;
      $display("grant %s reg%0d data=%h", (win == 0) ? "ALU" : "MEM", wr, wd);
      m_last = win;
      m_pref = 1 - win;
      if (wr == 3'd0) begin
        m_reg = '0;
        m_val = '0;
      end else begin
        m_we  = 1'b1;
        m_reg = wr;
        m_val = wd;
        exp_q.push_back('{cyc: cyc + 1, r: wr, d: wd});
      end
    end
  endtask

  task automatic idle();
    bit ga, gm;
    step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, ga, gm);
  endtask

  initial begin
    bit         ga, gm;
    bit         pa_v, pm_v;
    logic [2:0] pa_r, pm_r;
    logic [15:0] pa_d, pm_d;

    model_reset();
    RST_N = 1'b0;
    alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 16'h1;
    mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 16'h2;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_RegWrite", {31'd0, RegWrite}, 0);
    chk("rst_writeReg", {29'd0, writeReg}, 0);
    chk("rst_writeValue", {16'd0, writeValue}, 0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 0);
    chk("rst_last_grant", {31'd0, last_grant}, 0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // Contended back-to-back traffic from reset: ALU, MEM, ALU, MEM.
    step(1, 3'd2, 16'h00A7, 1, 3'd6, 16'h0013, ga, gm);
    step(1, 3'd4, 16'h1111, 1, 3'd6, 16'h0013, ga, gm);
    step(1, 3'd4, 16'h1111, 1, 3'd5, 16'h2222, ga, gm);
    step(0, 3'd0, 16'h0000, 1, 3'd5, 16'h2222, ga, gm);
    idle();
    // Single uncontended ALU write.
    step(1, 3'd3, 16'hABCD, 0, 3'd0, 16'h0, ga, gm);
    idle();
    idle();
    // Write to register 0 is accepted and dropped.
    step(0, 3'd0, 16'h0, 1, 3'd0, 16'h2030, ga, gm);
    idle();
    // Same destination from both sides serialises in grant order.
    step(1, 3'd7, 16'h1234, 1, 3'd7, 16'h5678, ga, gm);
    step(0, 3'd0, 16'h0, 1, 3'd7, 16'h5678, ga, gm);
    idle();
    // Move the pointer to MEM, then let MEM hold the ALU off.
    step(1, 3'd2, 16'h0F0F, 0, 3'd0, 16'h0, ga, gm);
    step(1, 3'd1, 16'hAAAA, 1, 3'd5, 16'h5555, ga, gm);
    step(1, 3'd1, 16'hAAAA, 0, 3'd0, 16'h0, ga, gm);
    idle();
    idle();

    // Reset while a write sits in the output stage.
    step(1, 3'd4, 16'h0BEE, 0, 3'd0, 16'h0, ga, gm);
    @(negedge CLK);
    #2;
    chk("pre_rst_RegWrite", {31'd0, RegWrite}, 1);
    alu_valid = 1'b1; alu_reg = 3'd3; mem_valid = 1'b1; mem_reg = 3'd6;
    RST_N = 1'b0;
    #1;
    chk("midrst_RegWrite", {31'd0, RegWrite}, 0);
    chk("midrst_writeReg", {29'd0, writeReg}, 0);
    chk("midrst_alu_ready", {31'd0, alu_ready}, 0);
    chk("midrst_mem_ready", {31'd0, mem_ready}, 0);
    model_reset();
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    step(1, 3'd3, 16'h3333, 1, 3'd6, 16'h6666, ga, gm);
    step(0, 3'd0, 16'h0, 1, 3'd6, 16'h6666, ga, gm);
    idle();

    // Random traffic: each requester holds its request until granted.
    pa_v = 0; pm_v = 0;
    pa_r = '0; pm_r = '0; pa_d = '0; pm_d = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pa_v && ($urandom_range(0, 2) != 0)) begin
        pa_v = 1; pa_r = 3'($urandom_range(0, 7)); pa_d = 16'($urandom);
      end
      if (!pm_v && ($urandom_range(0, 2) != 0)) begin
        pm_v = 1; pm_r = 3'($urandom_range(0, 7)); pm_d = 16'($urandom);
      end
      step(pa_v, pa_r, pa_d, pm_v, pm_r, pm_d, ga, gm);
      if (ga) pa_v = 0;
      if (gm) pm_v = 0;
    end
    idle();
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU result path and the memory-load path.
- Round-robin arbitration; one write per cycle through a one-deep registered output stage that drives RegWrite/writeReg/writeValue.
- Writes to register 0 are accepted and silently dropped.
- Exports a pending-write mask so decode can stall on registers with an outstanding write.

Parameters:
- DATA_W, 16, writeback data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count; must equal 2**ADDR_W

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU writeback value
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load writeback value
- mem_ready  out  1  load request accepted this cycle
- RegWrite  out  1  register-file write enable, registered
- writeReg  out  ADDR_W  register-file write address, registered
- writeValue  out  DATA_W  register-file write data, registered
- busy_mask  out  NUM_REGS  registers with a pending write, combinational
- last_grant  out  1  last granted requester: 0 = ALU, 1 = MEM

Behaviour:
- Handshake:
  - A transfer occurs at a rising edge where valid && ready.
  - The requester holds valid, reg and data stable until that edge; valid does not drop before ready.
  - ready is combinational from both valids and the priority pointer, and does not depend on that requester's own data.
- Arbitration:
  - Only one requester valid: it gets ready=1.
  - Both valid: the requester the pointer prefers gets ready=1 and the other gets 0.
  - The pointer moves to the non-granted requester after every grant, including uncontended grants.
  - The pointer holds when there is no grant.
  - last_grant shows the requester granted most recently.
- Throughput: one grant per cycle maximum. The output stage never back-pressures, because the register file accepts a write every cycle.
- Latency:
  - Grant at edge N loads the output stage.
  - RegWrite=1 with writeReg/writeValue stable during cycle N to N+1.
  - The register file commits at edge N+1.
  - A cycle with no grant loads RegWrite=0; writeReg and writeValue hold their previous values.
- Register 0: a request to reg 0 is granted normally and updates the pointer. The output stage loads RegWrite=0, writeReg=0, writeValue=0.
- busy_mask, bit i, for i=1..NUM_REGS-1, is set when any of these is true:
  - RegWrite && writeReg==i
  - alu_valid && alu_reg==i
  - mem_valid && mem_reg==i
  - Bit 0 is always 0.
- Same destination register from both requesters in one cycle:
  - They serialize in grant order; the later grant's data wins.
  - No merging and no dropping.
- Reset:
  - RST_N low asynchronously forces RegWrite=0, writeReg=0, writeValue=0, pointer=ALU, last_grant=0.
  - While RST_N is low, alu_ready=0 and mem_ready=0.
  - A write held in the output stage when reset asserts is discarded and never reaches the register file.
  - First grant is possible at the first rising edge after RST_N deasserts.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W
  - Requester encoding: REQ_ALU=0, REQ_MEM=1
  - ZERO_REG=0
- Natural sub-module: rr_arb2, a two-input round-robin arbiter with pointer state; request/grant/advance, async active-low reset.
- Output stage and busy_mask stay in the top module.

Test Plan:
- ALU only, alu_reg=3, alu_data=16'hABCD for 1 cycle -> alu_ready=1 that cycle; next cycle RegWrite=1, writeReg=3, writeValue=16'hABCD; the cycle after, RegWrite=0.
- Both valid every cycle from reset: ALU reg2=16'h00A7 then reg4=16'h1111; MEM reg6=16'h0013 then reg5=16'h2222 -> grants ALU, MEM, ALU, MEM; writes appear on consecutive cycles in that order.
- Write to reg 0: mem_reg=0, mem_data=16'h2030 -> mem_ready=1; RegWrite stays 0; pointer advances to ALU.
- Same destination: both valid to reg 7, ALU=16'h1234, MEM=16'h5678, pointer=ALU -> reg 7 written with 16'h1234 then 16'h5678 on consecutive cycles.
- busy_mask: ALU valid to reg 1 held off by MEM to reg 5 -> busy_mask=8'b0010_0010; next cycle 8'b0010_0010, since reg 5 is in the output stage and reg 1 is still pending; then 8'b0000_0010.
- Reset mid-write: assert RST_N low while RegWrite=1 to reg 4 -> RegWrite drops immediately; both readies drop to 0; after release the pointer prefers ALU.
